// File: rtl/go_initiator.sv
// Run-request initiator: debounces the board button, issues go to the counting FSM,
// counts completed runs and flags runs that never report done.
module go_initiator #(
  parameter int unsigned DEBOUNCE_CYCLES = 300000,
  parameter int unsigned TIMEOUT_CYCLES  = 150000000
) (
  input  logic       clk30,
  input  logic       rst,
  input  logic       btn_n,
  input  logic       done,
  output logic       go,
  output logic       busy,
  output logic [3:0] run_count,
  output logic       timeout_err
);

  localparam logic [31:0] DEB_LAST = 32'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    REPORT = 2'd2,
    ERROR  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        btn_meta;
  logic        btn_sync;
  logic        done_meta;
  logic        done_sync;
  logic        done_prev;
  logic        done_edge;
  logic [31:0] deb_cnt;
  logic        deb_level;
  logic        deb_prev;
  logic        press;
  logic [31:0] tmo_cnt;

  // The button is inverted on entry so that cleared flops read as "released".
  always_ff @(posedge clk30 or posedge rst) begin
    if (rst) begin
      btn_meta  <= 1'b0;
      btn_sync  <= 1'b0;
      done_meta <= 1'b0;
      done_sync <= 1'b0;
      done_prev <= 1'b0;
      done_edge <= 1'b0;
    end else begin
      btn_meta  <= ~btn_n;
      btn_sync  <= btn_meta;
      done_meta <= done;
      done_sync <= done_meta;
      done_prev <= done_sync;
      done_edge <= done_sync & ~done_prev;
    end
  end

  always_ff @(posedge clk30 or posedge rst) begin
    if (rst) begin
      deb_cnt   <= '0;
      deb_level <= 1'b0;
      deb_prev  <= 1'b0;
    end else begin
      deb_prev <= deb_level;
      if (btn_sync == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb_level <= ~deb_level;
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + 32'd1;
      end
    end
  end

  assign press = deb_level & ~deb_prev;

  always_ff @(posedge clk30 or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      run_count <= '0;
    end else begin
      state <= state_next;
      if (state == ACTIVE) begin
        tmo_cnt <= tmo_cnt + 32'd1;
      end else begin
        tmo_cnt <= '0;
      end
      if (state == REPORT) begin
        run_count <= run_count + 4'd1;
      end
    end
  end

  // A done edge takes priority over a timeout landing in the same cycle.
  always_comb begin
    state_next  = IDLE;
    go          = 1'b0;
    busy        = 1'b0;
    timeout_err = 1'b0;
    case (state)
      IDLE: begin
        state_next = press ? ACTIVE : IDLE;
      end
      ACTIVE: begin
        go   = 1'b1;
        busy = 1'b1;
        if (done_edge) begin
          state_next = REPORT;
        end else if (tmo_cnt == TMO_LAST) begin
          state_next = ERROR;
        end else begin
          state_next = ACTIVE;
        end
      end
      REPORT: begin
        state_next = IDLE;
      end
      ERROR: begin
        timeout_err = 1'b1;
        state_next  = press ? IDLE : ERROR;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_go_initiator.sv
// Bench for go_initiator: an edge-indexed behavioural model checked every cycle,
// directed latency/boundary scenarios with literal expectations, then random stimulus.
module tb_go_initiator;

  localparam int D = 4;
  localparam int T = 20;

  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_REPORT = 2;
  localparam int M_ERR    = 3;

  logic       clk30;
  logic       rst;
  logic       btn_n;
  logic       done;
  logic       go;
  logic       busy;
  logic [3:0] run_count;
  logic       timeout_err;

  int n_cmp = 0;
  int n_bad = 0;

  go_initiator #(
    .DEBOUNCE_CYCLES(D),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk30      (clk30),
    .rst        (rst),
    .btn_n      (btn_n),
    .done       (done),
    .go         (go),
    .busy       (busy),
    .run_count  (run_count),
    .timeout_err(timeout_err)
  );

  initial clk30 = 1'b0;
  always #5 clk30 = ~clk30;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: edges are numbered from 1 after reset release; samples before that read as 0.
  int edge_n  = 0;
  int m_mode  = M_IDLE;
  int m_entry = 0;
  int m_count = 0;
  bit m_deb   = 1'b0;
  bit m_rose  = 1'b0;
  bit btn_h[64];
  bit done_h[64];

  function automatic bit hb(input int i);
    if (i < 1) return 1'b0;
    return btn_h[i % 64];
  endfunction

  function automatic bit hd(input int i);
    if (i < 1) return 1'b0;
    return done_h[i % 64];
  endfunction

  always @(posedge clk30 or posedge rst) begin : model_p
    bit de;
    bit pr;
    bit all_diff;
    if (rst) begin
      edge_n  = 0;
      m_mode  = M_IDLE;
      m_count = 0;
      m_deb   = 1'b0;
      m_rose  = 1'b0;
    end else begin
      edge_n++;
      btn_h[edge_n % 64]  = ~btn_n;
      done_h[edge_n % 64] = done;
      pr = m_rose;
      de = hd(edge_n - 3) & ~hd(edge_n - 4);
      case (m_mode)
        M_IDLE:   if (pr) begin m_mode = M_RUN; m_entry = edge_n; end
        M_RUN:    if (de) m_mode = M_REPORT;
                  else if (edge_n - m_entry == T) m_mode = M_ERR;
        M_REPORT: begin m_mode = M_IDLE; m_count = (m_count + 1) % 16; end
        default:  if (pr) m_mode = M_IDLE;
      endcase
      // The debounced level flips once the last D synchronised samples all disagree with it.
      all_diff = 1'b1;
      for (int i = 0; i < D; i++) begin
        if (hb(edge_n - 2 - i) == m_deb) all_diff = 1'b0;
      end
      m_rose = 1'b0;
      if (all_diff) begin
        m_deb  = ~m_deb;
        m_rose = m_deb;
      end
    end
    #1;
    check_output("model_go",          32'(go),          32'(m_mode == M_RUN));
    check_output("model_busy",        32'(busy),        32'(m_mode == M_RUN));
    check_output("model_timeout_err", 32'(timeout_err), 32'(m_mode == M_ERR));
    check_output("model_run_count",   32'(run_count),   32'(m_count));
  end

  task automatic goto_edge(input int target);
    int guard;
    guard = 0;
    while (edge_n < target) begin
      @(posedge clk30);
      #2;
      guard++;
      if (guard > 5000) begin
        n_cmp++;
        n_bad++;
        $display("[TB] FAIL goto_edge: actual=%0d required=%0d", edge_n, target);
        break;
      end
    end
  endtask

  task automatic apply_stimulus(input bit b, input bit d);
    btn_n = b;
    done  = d;
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: actual=%0d required=%0d", edge_n, 0);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int e;
    int dly;
    int len;
    rst = 1'b0;
    apply_stimulus(1'b1, 1'b0);
    #1 rst = 1'b1;
    #19;
    check_output("reset_go",          32'(go),          32'd0);
    check_output("reset_busy",        32'(busy),        32'd0);
    check_output("reset_run_count",   32'(run_count),   32'd0);
    check_output("reset_timeout_err", 32'(timeout_err), 32'd0);
    #12 rst = 1'b0;

    // Press sampled from edge 10, then done high for 8 samples from edge 30.
    goto_edge(9);  apply_stimulus(1'b0, 1'b0);
    goto_edge(15); check_output("press_go_early", 32'(go), 32'd0);
    goto_edge(16); check_output("press_go", 32'(go), 32'd1);
                   check_output("press_busy", 32'(busy), 32'd1);
    goto_edge(29); apply_stimulus(1'b0, 1'b1);
    goto_edge(32); check_output("done_go_held", 32'(go), 32'd1);
    goto_edge(33); check_output("done_go_low", 32'(go), 32'd0);
                   check_output("done_count_before", 32'(run_count), 32'd0);
    goto_edge(34); check_output("done_count_after", 32'(run_count), 32'd1);
    goto_edge(37); apply_stimulus(1'b0, 1'b0);
    goto_edge(45); check_output("done_single_inc", 32'(run_count), 32'd1);
    apply_stimulus(1'b1, 1'b0);

    // Timeout: press sampled at 56, ACTIVE from 62, ERROR at 82.
    goto_edge(55); apply_stimulus(1'b0, 1'b0);
    goto_edge(81); check_output("tmo_go_last", 32'(go), 32'd1);
                   check_output("tmo_err_early", 32'(timeout_err), 32'd0);
    goto_edge(82); check_output("tmo_err", 32'(timeout_err), 32'd1);
                   check_output("tmo_go_low", 32'(go), 32'd0);
    apply_stimulus(1'b1, 1'b0);
    goto_edge(95); apply_stimulus(1'b0, 1'b0);
    goto_edge(101); check_output("err_hold", 32'(timeout_err), 32'd1);
    goto_edge(102); check_output("err_clear", 32'(timeout_err), 32'd0);
                    check_output("err_count", 32'(run_count), 32'd1);
    apply_stimulus(1'b1, 1'b0);

    // Short bounces.
    goto_edge(115);
    for (int g = 0; g < 5; g++) begin
      e = edge_n;
      apply_stimulus(1'b0, 1'b0);
      goto_edge(e + 3);
      apply_stimulus(1'b1, 1'b0);
      goto_edge(e + 8);
    end
    goto_edge(edge_n + 10);
    check_output("glitch_go", 32'(go), 32'd0);

    // done edge lands on the timeout cycle.
    e = edge_n;
    apply_stimulus(1'b0, 1'b0);
    goto_edge(e + 7);  apply_stimulus(1'b1, 1'b0);
    goto_edge(e + 23); apply_stimulus(1'b1, 1'b1);
    goto_edge(e + 26); check_output("race_go_held", 32'(go), 32'd1);
    goto_edge(e + 27); check_output("race_go_low", 32'(go), 32'd0);
                       check_output("race_no_err", 32'(timeout_err), 32'd0);
    goto_edge(e + 28); check_output("race_count", 32'(run_count), 32'd2);
                       check_output("race_no_err2", 32'(timeout_err), 32'd0);
    goto_edge(e + 30); apply_stimulus(1'b1, 1'b0);
    goto_edge(e + 40);

    // Sixteen complete runs wrap the count back to its start.
    for (int r = 0; r < 16; r++) begin
      e   = edge_n;
      dly = $urandom_range(0, 8);
      len = $urandom_range(1, 5);
      apply_stimulus(1'b0, 1'b0);
      goto_edge(e + 8);
      apply_stimulus(1'b1, 1'b0);
      goto_edge(e + 8 + dly);
      apply_stimulus(1'b1, 1'b1);
      goto_edge(e + 8 + dly + len);
      apply_stimulus(1'b1, 1'b0);
      goto_edge(e + 8 + dly + len + 12);
    end
    check_output("wrap_count", 32'(run_count), 32'd2);

    // Reset in the middle of a run, button kept held through it.
    e = edge_n;
    apply_stimulus(1'b0, 1'b0);
    goto_edge(e + 9);
    check_output("mid_go_before", 32'(go), 32'd1);
    #1 rst = 1'b1;
    #1;
    check_output("mid_rst_go", 32'(go), 32'd0);
    check_output("mid_rst_busy", 32'(busy), 32'd0);
    check_output("mid_rst_count", 32'(run_count), 32'd0);
    repeat (2) @(posedge clk30);
    #3 rst = 1'b0;
    goto_edge(6); check_output("post_rst_go_early", 32'(go), 32'd0);
    goto_edge(7); check_output("post_rst_go", 32'(go), 32'd1);
    apply_stimulus(1'b1, 1'b0);
    goto_edge(edge_n + 30);

    // Random button and done activity.
    for (int i = 0; i < 400; i++) begin
      apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
      goto_edge(edge_n + $urandom_range(1, 8));
    end
    goto_edge(edge_n + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
